// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default baud divisor and the
// line-state encoding used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 5208;  // 50 MHz / 9600 baud

    // Line state encoding; the enum values are the state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO in front of the UART transmitter.
// Pointers wrap naturally; count distinguishes full from empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          soft_rst,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 do_wr;
    logic                 do_rd;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Writes are dropped when full and reads are dropped when empty.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
    end

    // Pointer and count registers; either reset flushes the queue.
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (!rst && !soft_rst && do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_ser.sv
// UART transmitter: queues bytes in a FIFO and sends them as 8N1 frames,
// LSB first. Line, busy and done are registered from the FSM state, so they
// all lag the state register by one cycle and stay mutually aligned.
//
// Handshake: a byte is taken on a rising edge where tx_valid && tx_ready.
// tx_ready depends only on the current FIFO count (not full), never on a
// same-cycle pop; tx_valid while full is ignored without side effects.
module uart_tx_fifo_ser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        soft_rst,
    input  logic [DATA_BITS-1:0]        tx_data_in,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx_data_out,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 line_q, line_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .soft_rst(soft_rst),
        .wr_en   (tx_valid),
        .wr_data (tx_data_in),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign tx_ready    = !fifo_full;
    assign tx_data_out = line_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;

    // Next-state logic: frame sequencing, baud countdown, shift and pop.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    baud_d  = BAUD_LAST;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_q == '0) begin
                    baud_d    = BAUD_LAST;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_LAST;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_q == '0) begin
                    // Chain straight into the next frame when more is queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        baud_d  = BAUD_LAST;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the current state, registered below.
    always_comb begin
        line_d = 1'b1;
        unique case (state_q)
            ST_START: line_d = 1'b0;
            ST_DATA:  line_d = shift_q[0];
            default:  line_d = 1'b1;
        endcase
        busy_d = (state_q != ST_IDLE);
        done_d = (state_q == ST_STOP) && (baud_q == '0);
    end

    // State and output registers; either reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            line_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            line_q    <= line_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_ser.sv
// Bench for uart_tx_fifo_ser: table-driven single frames, hand-written
// multi-cycle sequences, a loop-back byte decoder and a full-rate smoke run.
module tb_uart_tx_fifo_ser;

    localparam int CPB    = 4;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int SLOW   = 5208;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          soft_rst = 1'b0;
    logic [7:0]    tx_data_in = 8'h00;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx_data_out;
    logic          tx_busy;
    logic          tx_done;
    logic [CW-1:0] fifo_count;

    logic          s_soft = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_line;
    logic          s_busy;
    logic          s_done;
    logic [CW-1:0] s_count;

    uart_tx_fifo_ser #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst),
        .tx_data_in(tx_data_in), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data_out(tx_data_out), .tx_busy(tx_busy), .tx_done(tx_done),
        .fifo_count(fifo_count)
    );

    uart_tx_fifo_ser #(.CLKS_PER_BIT(SLOW), .FIFO_DEPTH(DEPTH)) dut_slow (
        .clk(clk), .rst(rst), .soft_rst(s_soft),
        .tx_data_in(s_data), .tx_valid(s_valid), .tx_ready(s_ready),
        .tx_data_out(s_line), .tx_busy(s_busy), .tx_done(s_done),
        .fifo_count(s_count)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- loop-back receiver ----------------
    // Samples each bit in its second cycle and checks bytes against exp_q.
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    int         rx_frames = 0;

    always @(negedge clk) begin
        if (rx_act && !tx_busy) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx_data_out === 1'b0 && !rst) begin
                rx_act = 1'b1;
                rx_cnt = 1;
            end
        end else begin
            int slot;
            rx_cnt++;
            slot = (rx_cnt - 1) / CPB;
            if ((rx_cnt - 1) % CPB == 1) begin
                if (slot == 0) begin
                    check("rx_start_bit", tx_data_out, 1'b0);
                end else if (slot <= 8) begin
                    rx_byte[slot-1] = tx_data_out;
                end else begin
                    check("rx_stop_bit", tx_data_out, 1'b1);
                    if (exp_q.size() == 0) check("rx_unexpected_frame", rx_byte, 32'hFFFF_FFFF);
                    else check("rx_byte", rx_byte, exp_q.pop_front());
                    rx_frames++;
                    rx_act = 1'b0;
                end
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic wait_low(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (tx_data_out === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Call on frame cycle 1 (first low cycle); returns on cycle 10*CPB.
    task automatic sample_frame(input logic [9:0] bits, input string tag);
        int line_err = 0;
        int done_err = 0;
        int busy_err = 0;
        for (int c = 1; c <= 10 * CPB; c++) begin
            if (tx_data_out !== bits[(c - 1) / CPB]) line_err++;
            if (tx_done !== (c == 10 * CPB)) done_err++;
            if (tx_busy !== 1'b1) busy_err++;
            if (c < 10 * CPB) @(negedge clk);
        end
        check({tag, "_line"}, line_err, 0);
        check({tag, "_done"}, done_err, 0);
        check({tag, "_busy"}, busy_err, 0);
    endtask

    task automatic wait_drained(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (exp_q.size() == 0 && !tx_busy && fifo_count == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_drained"}, ok, 1'b1);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // bit i = line level in bit slot i
    } vec_t;
    vec_t vecs[6];

    initial begin
        bit ok;
        int peak;
        int err;
        int cyc, run, nr, done_cyc;
        logic prev;
        int runs[10];

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'hC3, 10'b1110000110};
        vecs[5] = '{8'h5A, 10'b1010110100};

        // reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_line", tx_data_out, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_count", fifo_count, 0);

        // single frames from the table
        for (int v = 0; v < 6; v++) begin
            tx_data_in = vecs[v].data;
            tx_valid = 1'b1;
            exp_q.push_back(vecs[v].data);
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data_in = 8'hEE;
            check("lat_count_after_push", fifo_count, 1);
            check("lat_line_after_push", tx_data_out, 1'b1);
            @(negedge clk);
            check("lat_line_after_pop", tx_data_out, 1'b1);
            check("lat_count_after_pop", fifo_count, 0);
            @(negedge clk);
            check("lat_line_falls", tx_data_out, 1'b0);
            sample_frame(vecs[v].frame, "single");
            @(negedge clk);
            check("single_idle_line", tx_data_out, 1'b1);
            check("single_idle_busy", tx_busy, 1'b0);
            check("single_idle_done", tx_done, 1'b0);
        end
        wait_drained("single");

        // burst of four: back-to-back frames
        peak = 0;
        fork
            begin
                for (int i = 1; i <= 4; i++) begin
                    tx_data_in = vecs[i].data;
                    tx_valid = 1'b1;
                    exp_q.push_back(vecs[i].data);
                    @(negedge clk);
                    if (fifo_count > peak) peak = fifo_count;
                end
                tx_valid = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (fifo_count > peak) peak = fifo_count;
                end
            end
            begin
                bit fell;
                wait_low(20, fell);
                check("burst_fall", fell, 1'b1);
                for (int i = 1; i <= 4; i++) begin
                    sample_frame(vecs[i].frame, "burst");
                    if (i < 4) @(negedge clk);
                end
            end
        join
        check("burst_peak_count", peak, 3);
        wait_drained("burst");

        // fill to full during a frame, then hold 0x77 until a slot frees
        for (int i = 0; i < 5; i++) begin
            tx_data_in = 8'(8'h01 << i);
            tx_valid = 1'b1;
            exp_q.push_back(8'(8'h01 << i));
            @(negedge clk);
        end
        tx_data_in = 8'h77;
        exp_q.push_back(8'h77);
        check("full_ready", tx_ready, 1'b0);
        check("full_count", fifo_count, 4);
        ok = 1'b0;
        err = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            if (fifo_count != 4) err++;
        end
        check("full_hold_count", err, 0);
        check("full_ready_returns", ok, 1'b1);
        check("full_count_at_ready", fifo_count, 3);
        @(negedge clk);
        tx_valid = 1'b0;
        check("full_accept_count", fifo_count, 4);
        check("full_accept_ready", tx_ready, 1'b0);
        wait_drained("full");

        // soft_rst during data bit 3 of 0x5A with two bytes queued
        tx_data_in = 8'h5A; tx_valid = 1'b1;
        @(negedge clk);
        tx_data_in = 8'h11;
        @(negedge clk);
        tx_data_in = 8'h22;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_low(10, ok);
        check("soft_fall", ok, 1'b1);
        check("soft_queued", fifo_count, 2);
        repeat (4 * CPB + 1) @(negedge clk);
        check("soft_bit3_line", tx_data_out, 1'b1);
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        check("soft_line", tx_data_out, 1'b1);
        check("soft_count", fifo_count, 0);
        check("soft_busy", tx_busy, 1'b0);
        check("soft_ready", tx_ready, 1'b1);
        err = 0;
        repeat (15 * CPB) begin
            if (tx_data_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) err++;
            @(negedge clk);
        end
        check("soft_quiet_after", err, 0);

        // rst held 3 cycles mid-frame with tx_valid high
        tx_data_in = 8'hC3; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_low(10, ok);
        check("hrst_fall", ok, 1'b1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        tx_valid = 1'b1;
        tx_data_in = 8'h66;
        err = 0;
        repeat (3) begin
            @(negedge clk);
            if (fifo_count !== 0 || tx_data_out !== 1'b1) err++;
        end
        rst = 1'b0;
        tx_valid = 1'b0;
        check("hrst_no_push", err, 0);
        @(negedge clk);
        check("hrst_ready", tx_ready, 1'b1);
        check("hrst_line", tx_data_out, 1'b1);
        check("hrst_done", tx_done, 1'b0);
        check("hrst_busy", tx_busy, 1'b0);
        check("hrst_count", fifo_count, 0);
        repeat (12 * CPB) @(negedge clk);
        check("hrst_still_idle", tx_busy, 1'b0);

        // full-rate smoke run on the 5208-cycle instance
        check("slow_ready", s_ready, 1'b1);
        s_data = 8'h55; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (s_line === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("slow_fall", ok, 1'b1);
        cyc = 1; run = 1; nr = 0; done_cyc = 0; prev = 1'b0;
        while (cyc < 60000 && done_cyc == 0) begin
            @(negedge clk);
            cyc++;
            if (s_line !== prev) begin
                if (nr < 10) runs[nr] = run;
                nr++;
                run = 1;
                prev = s_line;
            end else begin
                run++;
            end
            if (s_done === 1'b1) done_cyc = cyc;
        end
        err = 0;
        for (int i = 0; i < 9 && i < nr; i++) if (runs[i] != SLOW) err++;
        check("slow_bit_widths", err, 0);
        check("slow_transitions", nr, 9);
        check("slow_stop_width", run, SLOW);
        check("slow_frame_len", done_cyc, 10 * SLOW);
        @(negedge clk);
        check("slow_idle_busy", s_busy, 1'b0);
        check("slow_idle_count", s_count, 0);

        // final scoreboard state
        check("sb_empty", exp_q.size(), 0);
        check("rx_frame_total", rx_frames, 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_ser.md
Name: uart_tx_fifo_ser

Overview:
Transmit-side UART serializer: accepts parallel bytes over a valid/ready handshake into a small FIFO and drives them onto the serial line as 8N1 frames, LSB first.
The serial output connects directly to the receiver's serial input (tx_data_out), so it is the upstream partner of the UART receiver.
Baud timing uses the same clock-per-bit count as the receiver, so one CLKS_PER_BIT value serves the whole link.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); must be >= 2
FIFO_DEPTH, 4, number of byte entries in the input FIFO; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
soft_rst  input  1  synchronous, active-high flush/abort; same effect as rst
tx_data_in  input  8  byte to transmit
tx_valid  input  1  tx_data_in valid this cycle
tx_ready  output  1  FIFO can accept a byte (not full)
tx_data_out  output  1  serial line, idle high, registered
tx_busy  output  1  frame in progress (START, DATA or STOP)
tx_done  output  1  one-cycle pulse at end of each stop bit
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued

Behaviour:
- Reset and soft_rst (both synchronous, active-high):
  - FIFO empties (fifo_count=0, tx_ready=1).
  - FSM returns to IDLE, tx_data_out=1, tx_busy=0, tx_done=0.
  - Any frame in flight is aborted; the line goes high on the next edge.
  - rst takes priority over soft_rst, which takes priority over all other activity.
- Push: a byte is written when tx_valid && tx_ready at a rising edge. If tx_valid is high while full, the byte is ignored with no side effect.
- Pop: the FSM reads the FIFO head only when leaving IDLE or STOP to start a frame.
- Simultaneous push and pop:
  - Allowed whenever the FIFO is not full; fifo_count is unchanged.
  - When full, tx_ready=0 in that cycle even though a pop occurs. tx_ready is registered/derived from the current count, never from a same-cycle pop.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when fifo_count!=0, pop the head into an 8-bit shift register, load the baud counter, and go to START.
  - START: line=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: line=shift[0] for CLKS_PER_BIT cycles per bit. Shift right at each bit boundary. After bit index 7 completes, go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles. At the last cycle, pulse tx_done. If fifo_count!=0, pop and go directly to START (back-to-back, zero idle gap); otherwise go to IDLE.
- Baud counter:
  - Counts CLKS_PER_BIT-1 down to 0, reloading at each bit boundary.
  - Each serial bit is exactly CLKS_PER_BIT cycles wide.
  - One frame is exactly 10*CLKS_PER_BIT cycles.
- Latency: for a push at edge N into an empty FIFO while IDLE:
  - fifo_count=1 after edge N.
  - The FSM pops at edge N+1.
  - tx_data_out falls after edge N+2.
- tx_busy=1 while in START, DATA or STOP, including the tx_done cycle if a back-to-back frame follows.
- Width rules:
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - fifo_count ranges 0..FIFO_DEPTH.
  - The baud counter is $clog2(CLKS_PER_BIT) bits.
- tx_data_in is sampled only on push; later changes do not affect queued or in-flight bytes.

Decomposition:
- Package uart_pkg:
  - state encoding localparams (IDLE, START, DATA, STOP)
  - DATA_BITS=8
  - default CLKS_PER_BIT
  - shared with the receiver.
- Sub-module uart_tx_fifo (synchronous FIFO, parameter FIFO_DEPTH).
  - Ports: clk, rst, soft_rst, wr_en, wr_data, rd_en, rd_data, full, empty, count.
  - The top level holds the FSM, baud counter and shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated):
- Single byte 0xA5 pushed while idle:
  - line falls 2 cycles after push.
  - then holds 0,1,0,1,0,0,1,0,1,1, each 4 cycles wide (start, LSB-first data, stop).
  - tx_done pulses once at cycle 40 of the frame.
- Push 0x00, 0xFF, 0x3C, 0xC3 in 4 consecutive cycles:
  - fifo_count peaks at 3, since the first byte is popped.
  - four frames go out back-to-back with no idle cycles.
  - each byte is reproduced exactly by a loop-back UART receiver with the same CLKS_PER_BIT.
- Fill FIFO to 4 while a frame is in flight, then hold tx_valid high with 0x77:
  - tx_ready=0.
  - 0x77 is not queued until a pop frees a slot; then it is accepted on the next edge.
- soft_rst asserted mid-DATA (bit 3 of 0x5A, 2 bytes queued):
  - line=1, fifo_count=0, tx_busy=0 next cycle.
  - no tx_done pulse.
  - no further frames.
- rst held 3 cycles during a frame, with tx_valid=1:
  - no push is accepted during reset.
  - after release, all outputs are at reset values: tx_ready=1, tx_data_out=1, tx_done=0.
- CLKS_PER_BIT=5208 smoke run, byte 0x55: every bit is exactly 5208 cycles; frame length is 52080 cycles.
